// File: rtl/uart_axi_responder.sv
// uart_axi_responder: AXI4-lite UART-Lite style register block over RX/TX byte-stream FIFOs.
// Read and write channels run independent two-state FSMs; every request gets one response.
module uart_axi_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  logic [7:0] din,
    output logic [7:0] head,
    output logic       empty,
    output logic       full
);
    localparam int AW = $clog2(DEPTH);
    logic [7:0]  mem [DEPTH];
    logic [AW:0] wp, rp;
    always_comb begin
        empty = wp == rp;
        full  = (wp ^ rp) == {1'b1, {AW{1'b0}}};
        head  = mem[rp[AW-1:0]];
    end
    // flush wins over a same-cycle push/pop, so the FIFO always ends empty
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wp[AW-1:0]] <= din;
    end
endmodule

module uart_axi_responder #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  uart_axi_araddr,
    input  logic        uart_axi_arvalid,
    output logic        uart_axi_arready,
    output logic [31:0] uart_axi_rdata,
    output logic [1:0]  uart_axi_rresp,
    output logic        uart_axi_rvalid,
    input  logic        uart_axi_rready,
    input  logic [3:0]  uart_axi_awaddr,
    input  logic        uart_axi_awvalid,
    output logic        uart_axi_awready,
    input  logic [31:0] uart_axi_wdata,
    input  logic [3:0]  uart_axi_wstrb,
    input  logic        uart_axi_wvalid,
    output logic        uart_axi_wready,
    output logic [1:0]  uart_axi_bresp,
    output logic        uart_axi_bvalid,
    input  logic        uart_axi_bready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_RESP} r_state_t;
    w_state_t    w_state, w_next;
    r_state_t    r_state, r_next;
    logic        w_hs, ar_hs, ctrl_wr, rd_err;
    logic [1:0]  w_sel, r_sel;
    logic        rx_push, rx_pop, rx_flush, rx_empty, rx_full;
    logic        tx_push, tx_pop, tx_flush, tx_empty, tx_full;
    logic [7:0]  rx_head, tx_head;
    logic        overrun, intr_en, ovr_set, ovr_clr;
    logic [31:0] stat, rd_val;
    logic        unused_bits;
    assign unused_bits = ^{uart_axi_araddr[1:0], uart_axi_awaddr[1:0], uart_axi_wdata[31:5],
                           uart_axi_wdata[3:2], uart_axi_wstrb[3:1]};
    always_comb begin
        r_sel = uart_axi_araddr[3:2];
        w_sel = uart_axi_awaddr[3:2];
        uart_axi_arready = r_state == R_IDLE && !rst;
        ar_hs = uart_axi_arready && uart_axi_arvalid;
        uart_axi_rvalid = r_state == R_RESP;
        r_next = ar_hs ? R_RESP : (uart_axi_rvalid && uart_axi_rready) ? R_IDLE : r_state;
        uart_axi_awready = w_state == W_IDLE && uart_axi_awvalid && uart_axi_wvalid && !rst;
        uart_axi_wready = uart_axi_awready;
        w_hs = uart_axi_awready;
        uart_axi_bvalid = w_state == W_RESP;
        w_next = w_hs ? W_RESP : (uart_axi_bvalid && uart_axi_bready) ? W_IDLE : w_state;
    end
    // a pop frees a slot in the same cycle, so a push to a full FIFO is still taken
    always_comb begin
        ctrl_wr  = w_hs && w_sel == 2'd3 && uart_axi_wstrb[0];
        rx_pop   = ar_hs && r_sel == 2'd0 && !rx_empty;
        rx_push  = rx_valid && (!rx_full || rx_pop);
        rx_flush = ctrl_wr && uart_axi_wdata[1];
        tx_pop   = !tx_empty && tx_ready;
        tx_push  = w_hs && w_sel == 2'd1 && uart_axi_wstrb[0] && (!tx_full || tx_pop);
        tx_flush = ctrl_wr && uart_axi_wdata[0];
        ovr_set  = rx_valid && rx_full && !rx_pop;
        ovr_clr  = ar_hs && r_sel == 2'd2;
        tx_valid = !tx_empty;
        tx_data  = tx_head;
        stat     = {26'd0, overrun, intr_en, tx_full, tx_empty, rx_full, !rx_empty};
        rd_err   = r_sel[0];
        rd_val   = r_sel == 2'd0 ? {24'd0, rx_empty ? 8'h00 : rx_head} :
                   r_sel == 2'd2 ? stat : 32'd0;
    end
    uart_axi_fifo #(.DEPTH(FIFO_DEPTH)) rx_fifo (
        .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .flush(rx_flush),
        .din(rx_data), .head(rx_head), .empty(rx_empty), .full(rx_full)
    );
    uart_axi_fifo #(.DEPTH(FIFO_DEPTH)) tx_fifo (
        .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .flush(tx_flush),
        .din(uart_axi_wdata[7:0]), .head(tx_head), .empty(tx_empty), .full(tx_full)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end
    // an overrun landing on the same edge as a STAT-read clear keeps the flag set
    always_ff @(posedge clk) begin
        if (rst) begin
            uart_axi_rdata <= '0;
            uart_axi_rresp <= '0;
            uart_axi_bresp <= '0;
            overrun        <= 1'b0;
            intr_en        <= 1'b0;
        end else begin
            if (ar_hs) begin
                uart_axi_rdata <= rd_val;
                uart_axi_rresp <= rd_err ? 2'b10 : 2'b00;
            end
            if (w_hs) uart_axi_bresp <= w_sel[0] ? 2'b00 : 2'b10;
            if (ctrl_wr) intr_en <= uart_axi_wdata[4];
            overrun <= ovr_set || (overrun && !ovr_clr);
        end
    end
endmodule

// File: tb/tb_uart_axi_responder.sv
// tb_uart_axi_responder: directed bench with a queue scoreboard and a small FIFO/flag model.
module tb_uart_axi_responder;
    logic        clk = 0, rst = 1;
    logic [3:0]  araddr = 0, awaddr = 0, wstrb = 0;
    logic        arvalid = 0, arready, rvalid, rready = 1;
    logic [31:0] rdata, wdata = 0;
    logic [1:0]  rresp, bresp;
    logic        awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 1;
    logic [7:0]  rx_data = 0, tx_data;
    logic        rx_valid = 0, tx_valid, tx_ready = 0;
    int          vectors = 0, miscompares = 0;
    logic [31:0] rq[$];
    logic [1:0]  rrq[$], bq[$];
    logic [7:0]  rx_m[$], tx_m[$];
    logic        ovr_m = 0, ien_m = 0;

    uart_axi_responder #(.FIFO_DEPTH(16)) dut (
        .clk(clk), .rst(rst),
        .uart_axi_araddr(araddr), .uart_axi_arvalid(arvalid), .uart_axi_arready(arready),
        .uart_axi_rdata(rdata), .uart_axi_rresp(rresp), .uart_axi_rvalid(rvalid), .uart_axi_rready(rready),
        .uart_axi_awaddr(awaddr), .uart_axi_awvalid(awvalid), .uart_axi_awready(awready),
        .uart_axi_wdata(wdata), .uart_axi_wstrb(wstrb), .uart_axi_wvalid(wvalid), .uart_axi_wready(wready),
        .uart_axi_bresp(bresp), .uart_axi_bvalid(bvalid), .uart_axi_bready(bready),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] stat_m();
        return {26'd0, ovr_m, ien_m, tx_m.size() == 16, tx_m.size() == 0,
                rx_m.size() == 16, rx_m.size() != 0};
    endfunction

    task automatic axi_read(input logic [3:0] a, input string tag);
        int n = 0;
        logic hs = 0;
        logic [31:0] d = 0;
        logic [1:0] r = 2'b10;
        if (a[3:2] == 2'd0) begin
            r = 0;
            if (rx_m.size() != 0) d = {24'd0, rx_m.pop_front()};
        end else if (a[3:2] == 2'd2) begin
            r = 0;
            d = stat_m();
            ovr_m = 0;
        end
        rq.push_back(d);
        rrq.push_back(r);
        @(negedge clk);
        araddr = a;
        arvalid = 1;
        while (!hs && n < 50) begin
            #1 hs = arready;
            @(negedge clk);
            n++;
        end
        arvalid = 0;
        n = 0;
        while (!rvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_rvalid"}, 32'(rvalid), 1);
        chk({tag, "_rdata"}, rdata, rq.pop_front());
        chk({tag, "_rresp"}, 32'(rresp), 32'(rrq.pop_front()));
    endtask

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s, input string tag);
        int n = 0;
        logic hs = 0;
        if (a[3:2] == 2'd1 && s[0] && tx_m.size() < 16) tx_m.push_back(d[7:0]);
        if (a[3:2] == 2'd3 && s[0]) begin
            if (d[0]) tx_m.delete();
            if (d[1]) rx_m.delete();
            ien_m = d[4];
        end
        bq.push_back(a[2] ? 2'b00 : 2'b10);
        @(negedge clk);
        awaddr = a;
        wdata = d;
        wstrb = s;
        awvalid = 1;
        wvalid = 1;
        while (!hs && n < 50) begin
            #1 hs = awready;
            @(negedge clk);
            n++;
        end
        awvalid = 0;
        wvalid = 0;
        n = 0;
        while (!bvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_bvalid"}, 32'(bvalid), 1);
        chk({tag, "_bresp"}, 32'(bresp), 32'(bq.pop_front()));
    endtask

    task automatic rx_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_valid = 1;
        if (rx_m.size() < 16) rx_m.push_back(b);
        else ovr_m = 1;
    endtask

    task automatic tx_pulse();
        @(negedge clk);
        tx_ready = 1;
        @(negedge clk);
        tx_ready = 0;
        if (tx_m.size() != 0) tx_m.delete(0);
    endtask

    initial begin
        awvalid = 1;
        wvalid = 1;
        arvalid = 1;
        repeat (2) @(negedge clk);
        chk("rst_arready", 32'(arready), 0);
        chk("rst_awready", 32'(awready), 0);
        chk("rst_wready", 32'(wready), 0);
        chk("rst_rvalid", 32'(rvalid), 0);
        chk("rst_bvalid", 32'(bvalid), 0);
        chk("rst_tx_valid", 32'(tx_valid), 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rresp", 32'(rresp), 0);
        chk("rst_bresp", 32'(bresp), 0);
        awvalid = 0;
        wvalid = 0;
        arvalid = 0;
        rst = 0;
        @(negedge clk);
        chk("post_rst_rvalid", 32'(rvalid), 0);
        chk("post_rst_bvalid", 32'(bvalid), 0);
        chk("post_rst_tx_valid", 32'(tx_valid), 0);

        axi_write(4'h4, 32'h41, 4'h1, "tx41");
        chk("tx41_valid", 32'(tx_valid), 1);
        chk("tx41_data", 32'(tx_data), 32'(tx_m[0]));
        axi_read(4'h8, "stat_tx1");
        tx_pulse();
        chk("tx_drained", 32'(tx_valid), 0);

        axi_write(4'h4, 32'h55, 4'h1, "tx55");
        for (int i = 0; i <= 16; i++) rx_byte(8'(i));
        @(negedge clk);
        rx_valid = 0;
        axi_read(4'h8, "stat_rx_full");
        for (int i = 0; i < 16; i++) axi_read(4'h0, "rx_pop");
        tx_pulse();
        chk("tx55_data_gone", 32'(tx_valid), 0);
        axi_read(4'h0, "rx_empty_read");
        axi_read(4'h8, "stat_rx_empty");

        rx_byte(8'h99);
        @(negedge clk);
        rx_valid = 0;
        axi_write(4'h0, 32'hAB, 4'hF, "wr_rx_slverr");
        axi_write(4'h8, 32'h03, 4'hF, "wr_stat_slverr");
        axi_read(4'h4, "rd_tx_slverr");
        axi_read(4'hC, "rd_ctrl_slverr");
        axi_read(4'h8, "stat_unchanged");
        axi_read(4'h1, "rx_lowbits_ignored");

        for (int i = 0; i < 20; i++) axi_write(4'h4, 32'h60 + 32'(i), 4'h1, "tx_fill");
        axi_read(4'h8, "stat_tx_full");
        chk("tx_full_head", 32'(tx_data), 32'h60);
        axi_write(4'hC, 32'h01, 4'h1, "ctrl_tx_flush");
        axi_read(4'h8, "stat_tx_flushed");
        chk("tx_flushed_valid", 32'(tx_valid), 0);
        axi_write(4'h4, 32'h12, 4'hE, "tx_nostrb");
        chk("tx_nostrb_valid", 32'(tx_valid), 0);

        @(negedge clk);
        awaddr = 4'h4;
        wdata = 32'h77;
        wstrb = 4'h1;
        awvalid = 1;
        wvalid = 0;
        bready = 0;
        for (int k = 0; k < 2; k++) begin
            #1 chk("aw_waits_for_w", 32'(awready), 0);
            @(negedge clk);
        end
        wvalid = 1;
        #1 chk("aw_hs_with_w", 32'(awready), 1);
        chk("w_hs_with_aw", 32'(wready), 1);
        @(negedge clk);
        tx_m.push_back(8'h77);
        wdata = 32'h78;
        for (int k = 0; k < 5; k++) begin
            #1 chk("bvalid_held", 32'(bvalid), 1);
            chk("next_write_blocked", 32'(awready), 0);
            @(negedge clk);
        end
        bready = 1;
        #1 chk("held_bresp", 32'(bresp), 0);
        @(negedge clk);
        #1 chk("next_write_accepted", 32'(awready), 1);
        @(negedge clk);
        awvalid = 0;
        wvalid = 0;
        tx_m.push_back(8'h78);
        chk("second_bvalid", 32'(bvalid), 1);
        @(negedge clk);
        chk("tx77_head", 32'(tx_data), 32'(tx_m[0]));

        axi_write(4'hC, 32'h10, 4'h1, "ctrl_intr_en");
        axi_read(4'h8, "stat_intr_en");

        axi_write(4'h4, 32'h79, 4'h1, "tx79");
        @(negedge clk);
        araddr = 4'h8;
        arvalid = 1;
        rready = 0;
        @(negedge clk);
        arvalid = 0;
        chk("pre_rst_rvalid", 32'(rvalid), 1);
        chk("pre_rst_tx_valid", 32'(tx_valid), 1);
        rst = 1;
        @(negedge clk);
        chk("abort_rvalid", 32'(rvalid), 0);
        chk("abort_tx_valid", 32'(tx_valid), 0);
        chk("abort_bvalid", 32'(bvalid), 0);
        rst = 0;
        rready = 1;
        rx_m.delete();
        tx_m.delete();
        ovr_m = 0;
        ien_m = 0;
        axi_read(4'h8, "stat_after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
